exu_csr: RTL and testbench

- CSR execute stage, directly downstream of the system-instruction decoder.
- Consumes the decoded CSR controls (source/dest CSR ids, read/write enables, op, source select, zero-extended uimm, rd id/enable) plus the rs1 operand value and PC.
- Holds the machine-mode CSR file, performs the read-modify-write, and handles ecall/mret redirects.
- Presents the rd writeback result through one registered valid/ready output stage to the writeback path.

---
 rtl/exu_csr.sv | 230 +++++++++++++++++++++++
 tb/tb_exu_csr.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_csr.sv
// CSR execute stage: machine-mode CSR file, read-modify-write, ecall/mret redirect,
// and a single registered valid/ready result stage toward writeback.
module exu_csr #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned CSR_ADDRW = 12,
  parameter int unsigned REG_ADDRW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [CSR_ADDRW-1:0] i_csrsid,
  input  logic                 i_csrsren,
  input  logic [CSR_ADDRW-1:0] i_csrdid,
  input  logic                 i_csrdwen,
  input  logic [1:0]           i_excsropt,
  input  logic                 i_excsrsrc,
  input  logic [XLEN-1:0]      i_imm,
  input  logic [XLEN-1:0]      i_rs1data,
  input  logic [REG_ADDRW-1:0] i_rdid,
  input  logic                 i_rdwen,
  input  logic                 i_ecall,
  input  logic                 i_mret,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [REG_ADDRW-1:0] o_rdid,
  output logic                 o_rdwen,
  output logic [XLEN-1:0]      o_rddata,
  output logic                 o_redirect,
  output logic [XLEN-1:0]      o_npc,
  output logic                 o_illegal
);

  localparam logic [CSR_ADDRW-1:0] AddrMstatus = CSR_ADDRW'(12'h300);
  localparam logic [CSR_ADDRW-1:0] AddrMtvec   = CSR_ADDRW'(12'h305);
  localparam logic [CSR_ADDRW-1:0] AddrMepc    = CSR_ADDRW'(12'h341);
  localparam logic [CSR_ADDRW-1:0] AddrMcause  = CSR_ADDRW'(12'h342);
  localparam logic [CSR_ADDRW-1:0] AddrMcycle  = CSR_ADDRW'(12'hB00);

  localparam logic [1:0] OpSys = 2'b00;
  localparam logic [1:0] OpRw  = 2'b01;
  localparam logic [1:0] OpRs  = 2'b10;
  localparam logic [1:0] OpRc  = 2'b11;

  // mstatus keeps only MIE/MPIE as state; MPP is hardwired to machine mode.
  logic                 mie_q, mie_d;
  logic                 mpie_q, mpie_d;
  logic [XLEN-1:0]      mtvec_q, mtvec_d;
  logic [XLEN-1:0]      mepc_q, mepc_d;
  logic [XLEN-1:0]      mcause_q, mcause_d;
  logic [XLEN-1:0]      mcycle_q, mcycle_d;

  logic                 valid_q, valid_d;
  logic                 rdwen_q, rdwen_d;
  logic                 redirect_q, redirect_d;
  logic                 illegal_q, illegal_d;
  logic [REG_ADDRW-1:0] rdid_q, rdid_d;
  logic [XLEN-1:0]      rddata_q, rddata_d;
  logic [XLEN-1:0]      npc_q, npc_d;

  logic                 accept;
  logic [XLEN-1:0]      mstatus_val;
  logic [XLEN-1:0]      csr_rdata;
  logic [XLEN-1:0]      old_val;
  logic [XLEN-1:0]      src_val;
  logic [XLEN-1:0]      new_val;
  logic                 is_sys;
  logic                 illegal;
  logic                 do_write;
  logic                 do_ecall;
  logic                 do_mret;

  function automatic logic csr_impl(input logic [CSR_ADDRW-1:0] addr);
    case (addr)
      AddrMstatus, AddrMtvec, AddrMepc, AddrMcause, AddrMcycle: csr_impl = 1'b1;
      default:                                                  csr_impl = 1'b0;
    endcase
  endfunction

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  always_comb begin
    mstatus_val       = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]    = mpie_q;
    mstatus_val[3]    = mie_q;
  end

  always_comb begin
    csr_rdata = '0;
    case (i_csrsid)
      AddrMstatus: csr_rdata = mstatus_val;
      AddrMtvec:   csr_rdata = mtvec_q;
      AddrMepc:    csr_rdata = mepc_q;
      AddrMcause:  csr_rdata = mcause_q;
      AddrMcycle:  csr_rdata = mcycle_q;
      default:     csr_rdata = '0;
    endcase
  end

  always_comb begin
    old_val = i_csrsren ? csr_rdata : '0;
    src_val = i_excsrsrc ? i_imm : i_rs1data;
    new_val = old_val;
    unique case (i_excsropt)
      OpRw:    new_val = src_val;
      OpRs:    new_val = old_val | src_val;
      OpRc:    new_val = old_val & ~src_val;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    is_sys   = (i_excsropt == OpSys);
    illegal  = (i_csrsren && !csr_impl(i_csrsid)) || (i_csrdwen && !csr_impl(i_csrdid)) ||
               (i_ecall && i_mret);
    do_write = accept && i_csrdwen && !is_sys && !illegal;
    do_ecall = accept && is_sys && i_ecall && !illegal;
    do_mret  = accept && is_sys && i_mret && !illegal;
  end

  // CSR next state; mcycle always counts, and an explicit write overrides the count.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mcycle_d = mcycle_q + XLEN'(1);
    if (do_write) begin
      case (i_csrdid)
        AddrMstatus: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        AddrMtvec:  mtvec_d = new_val;
        AddrMepc: begin
          mepc_d    = new_val;
          mepc_d[0] = 1'b0;
        end
        AddrMcause: mcause_d = new_val;
        AddrMcycle: mcycle_d = new_val;
        default: ;
      endcase
    end
    if (do_ecall) begin
      mepc_d    = i_pc;
      mepc_d[0] = 1'b0;
      mcause_d  = XLEN'(11);
      mpie_d    = mie_q;
      mie_d     = 1'b0;
    end
    if (do_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_comb begin
    valid_d    = valid_q;
    rdwen_d    = rdwen_q;
    redirect_d = redirect_q;
    illegal_d  = illegal_q;
    rdid_d     = rdid_q;
    rddata_d   = rddata_q;
    npc_d      = npc_q;
    if (accept) begin
      valid_d    = 1'b1;
      rdid_d     = i_rdid;
      rddata_d   = old_val;
      illegal_d  = illegal;
      // A system op with neither ecall nor mret is a no-op and never writes rd.
      rdwen_d    = i_rdwen && !illegal && !(is_sys && !i_ecall && !i_mret);
      redirect_d = is_sys && (i_ecall || i_mret) && !illegal;
      npc_d      = '0;
      if (is_sys && !illegal) begin
        if (i_ecall) begin
          npc_d = {mtvec_q[XLEN-1:2], 2'b00};
        end else if (i_mret) begin
          npc_d = mepc_q;
        end
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      valid_q    <= 1'b0;
      rdwen_q    <= 1'b0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
      rdid_q     <= '0;
      rddata_q   <= '0;
      npc_q      <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      valid_q    <= valid_d;
      rdwen_q    <= rdwen_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
      rdid_q     <= rdid_d;
      rddata_q   <= rddata_d;
      npc_q      <= npc_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_rdid     = rdid_q;
  assign o_rdwen    = rdwen_q;
  assign o_rddata   = rddata_q;
  assign o_redirect = redirect_q;
  assign o_npc      = npc_q;
  assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_exu_csr.sv
// Bench for exu_csr: directed scenarios plus random traffic against an address-keyed CSR model.
module tb_exu_csr;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_pc;
  logic [11:0] i_csrsid;
  logic        i_csrsren;
  logic [11:0] i_csrdid;
  logic        i_csrdwen;
  logic [1:0]  i_excsropt;
  logic        i_excsrsrc;
  logic [63:0] i_imm;
  logic [63:0] i_rs1data;
  logic [4:0]  i_rdid;
  logic        i_rdwen;
  logic        i_ecall;
  logic        i_mret;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_rdid;
  logic        o_rdwen;
  logic [63:0] o_rddata;
  logic        o_redirect;
  logic [63:0] o_npc;
  logic        o_illegal;

  int total;
  int bad;

  // Model: CSR contents by address (presence == implemented), plus expected result stage.
  logic [63:0] csr_m [logic [11:0]];
  logic        exp_valid;
  logic [4:0]  exp_rdid;
  logic        exp_rdwen;
  logic [63:0] exp_rddata;
  logic        exp_redirect;
  logic [63:0] exp_npc;
  logic        exp_illegal;

  exu_csr #(.XLEN(64), .CSR_ADDRW(12), .REG_ADDRW(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
    .i_csrsid(i_csrsid), .i_csrsren(i_csrsren), .i_csrdid(i_csrdid), .i_csrdwen(i_csrdwen),
    .i_excsropt(i_excsropt), .i_excsrsrc(i_excsrsrc), .i_imm(i_imm), .i_rs1data(i_rs1data),
    .i_rdid(i_rdid), .i_rdwen(i_rdwen), .i_ecall(i_ecall), .i_mret(i_mret), .o_valid(o_valid),
    .i_ready(i_ready), .o_rdid(o_rdid), .o_rdwen(o_rdwen), .o_rddata(o_rddata),
    .o_redirect(o_redirect), .o_npc(o_npc), .o_illegal(o_illegal)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [63:0] mrd(input logic [11:0] a);
    return csr_m.exists(a) ? csr_m[a] : 64'h0;
  endfunction

  task automatic mdl_reset();
    csr_m.delete();
    csr_m[12'h300] = 64'h1800;
    csr_m[12'h305] = 64'h0;
    csr_m[12'h341] = 64'h0;
    csr_m[12'h342] = 64'h0;
    csr_m[12'hB00] = 64'h0;
    exp_valid = 0; exp_rdid = 0; exp_rdwen = 0; exp_rddata = 0;
    exp_redirect = 0; exp_npc = 0; exp_illegal = 0;
  endtask

  task automatic set_idle();
    i_valid = 0; i_csrsid = 0; i_csrsren = 0; i_csrdid = 0; i_csrdwen = 0; i_excsropt = 0;
    i_excsrsrc = 0; i_imm = 0; i_rs1data = 0; i_rdid = 0; i_rdwen = 0; i_ecall = 0;
    i_mret = 0; i_pc = 0;
  endtask

  task automatic drive(input logic [11:0] sid, input logic sren, input logic [11:0] did,
                       input logic dwen, input logic [1:0] op, input logic srcsel,
                       input logic [63:0] val, input logic [4:0] rd, input logic rdwen);
    i_valid = 1; i_csrsid = sid; i_csrsren = sren; i_csrdid = did; i_csrdwen = dwen;
    i_excsropt = op; i_excsrsrc = srcsel;
    i_imm = srcsel ? val : {$urandom, $urandom};
    i_rs1data = srcsel ? {$urandom, $urandom} : val;
    i_rdid = rd; i_rdwen = rdwen; i_ecall = 0; i_mret = 0; i_pc = {$urandom, $urandom};
  endtask

  task automatic drive_sys(input logic ec, input logic mr, input logic [63:0] pc);
    set_idle();
    i_valid = 1; i_ecall = ec; i_mret = mr; i_pc = pc;
  endtask

  // Advance one clock; the model applies the spec's rules at the edge.
  task automatic step();
    logic acc, sys, ill, redir, wr, ec, mr;
    logic [63:0] old, src, nv, npc, pc, ms;
    logic [11:0] wa;
    acc = i_valid && (!exp_valid || i_ready);
    sys = (i_excsropt == 2'b00);
    old = i_csrsren ? mrd(i_csrsid) : 64'h0;
    src = i_excsrsrc ? i_imm : i_rs1data;
    case (i_excsropt)
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    ill = (i_csrsren && !csr_m.exists(i_csrsid)) || (i_csrdwen && !csr_m.exists(i_csrdid)) ||
          (i_ecall && i_mret);
    redir = sys && (i_ecall || i_mret) && !ill;
    npc = !redir ? 64'h0 : (i_ecall ? (mrd(12'h305) & ~64'h3) : mrd(12'h341));
    wr = i_csrdwen && !sys && !ill;
    wa = i_csrdid;
    ec = redir && i_ecall;
    mr = redir && i_mret;
    pc = i_pc;
    if (acc) begin
      exp_rdid = i_rdid;
      exp_rddata = old;
      exp_illegal = ill;
      exp_redirect = redir;
      exp_npc = npc;
      exp_rdwen = i_rdwen && !ill && !(sys && !i_ecall && !i_mret);
    end
    @(posedge i_clk);
    csr_m[12'hB00] = csr_m[12'hB00] + 64'd1;
    if (acc) begin
      exp_valid = 1;
      if (wr) begin
        if (wa == 12'h300) csr_m[wa] = (nv & 64'h88) | 64'h1800;
        else if (wa == 12'h341) csr_m[wa] = nv & ~64'h1;
        else csr_m[wa] = nv;
      end
      if (ec) begin
        csr_m[12'h341] = pc & ~64'h1;
        csr_m[12'h342] = 64'd11;
        ms = csr_m[12'h300];
        ms[7] = ms[3];
        ms[3] = 1'b0;
        csr_m[12'h300] = ms;
      end
      if (mr) begin
        ms = csr_m[12'h300];
        ms[3] = ms[7];
        ms[7] = 1'b1;
        csr_m[12'h300] = ms;
      end
    end else if (i_ready) begin
      exp_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    set_idle();
    i_ready = 1;
    mdl_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
  endtask

  task automatic rd_csr(input logic [11:0] a);
    drive(a, 1, a, 0, 2'b10, 0, 64'h0, 5'd1, 1);
    step();
    set_idle();
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
    if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", o_ready); end
    if (o_rddata !== 64'h0) begin bad++; $display("FAIL reset_rddata got=%h want=0", o_rddata); end
    if ({o_rdwen, o_redirect, o_illegal} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {o_rdwen, o_redirect, o_illegal});
    end
    if ({o_npc, o_rdid} !== 69'h0) begin bad++; $display("FAIL reset_npc_rdid got=%h", o_npc); end
    rd_csr(12'h300);
    if (o_rddata !== 64'h1800) begin bad++; $display("FAIL reset_mstatus got=%h want=1800", o_rddata); end
  endtask

  task automatic test_rw_mtvec();
    do_reset();
    drive(12'h305, 1, 12'h305, 1, 2'b01, 0, 64'h8000_0100, 5'd5, 1);
    step();
    set_idle();
    total += 3;
    if ({o_valid, o_rdwen} !== 2'b11) begin bad++; $display("FAIL rw_valid got=%b want=11", {o_valid, o_rdwen}); end
    if (o_rdid !== 5'd5) begin bad++; $display("FAIL rw_rdid got=%0d want=5", o_rdid); end
    if (o_rddata !== 64'h0) begin bad++; $display("FAIL rw_old got=%h want=0", o_rddata); end
    rd_csr(12'h305);
    total++;
    if (o_rddata !== 64'h8000_0100) begin bad++; $display("FAIL rw_readback got=%h want=80000100", o_rddata); end
  endtask

  task automatic test_mstatus_rc();
    drive(12'h300, 0, 12'h300, 1, 2'b01, 0, 64'h8, 5'd0, 0);
    step();
    drive(12'h300, 1, 12'h300, 1, 2'b11, 1, 64'h8, 5'd6, 1);
    step();
    total++;
    if (o_rddata !== 64'h1808) begin bad++; $display("FAIL csrrci_old got=%h want=1808", o_rddata); end
    drive(12'h300, 1, 12'h300, 0, 2'b10, 1, 64'h0, 5'd6, 1);
    step();
    total++;
    if (o_rddata !== 64'h1800) begin bad++; $display("FAIL csrrci_new got=%h want=1800", o_rddata); end
    rd_csr(12'h300);
    total++;
    if (o_rddata !== 64'h1800) begin bad++; $display("FAIL csrrsi0_keep got=%h want=1800", o_rddata); end
  endtask

  task automatic test_ecall_mret();
    drive(12'h300, 0, 12'h300, 1, 2'b01, 0, 64'h8, 5'd0, 0);
    step();
    drive(12'h305, 0, 12'h305, 1, 2'b01, 0, 64'h8000_0103, 5'd0, 0);
    step();
    drive_sys(1, 0, 64'h8000_0040);
    step();
    set_idle();
    total += 3;
    if (o_redirect !== 1'b1) begin bad++; $display("FAIL ecall_redirect got=%0b want=1", o_redirect); end
    if (o_npc !== 64'h8000_0100) begin bad++; $display("FAIL ecall_npc got=%h want=80000100", o_npc); end
    if ({o_rdwen, o_illegal} !== 2'b00) begin bad++; $display("FAIL ecall_flags got=%b want=00", {o_rdwen, o_illegal}); end
    rd_csr(12'h341);
    total++;
    if (o_rddata !== 64'h8000_0040) begin bad++; $display("FAIL ecall_mepc got=%h want=80000040", o_rddata); end
    rd_csr(12'h342);
    total++;
    if (o_rddata !== 64'd11) begin bad++; $display("FAIL ecall_mcause got=%h want=b", o_rddata); end
    rd_csr(12'h300);
    total++;
    if (o_rddata !== 64'h1880) begin bad++; $display("FAIL ecall_mstatus got=%h want=1880", o_rddata); end
    drive_sys(0, 1, 64'h1234);
    step();
    set_idle();
    total++;
    if ({o_redirect, o_npc} !== {1'b1, 64'h8000_0040}) begin
      bad++; $display("FAIL mret_npc got=%b/%h want=1/80000040", o_redirect, o_npc);
    end
    rd_csr(12'h300);
    total++;
    if (o_rddata !== 64'h1888) begin bad++; $display("FAIL mret_mstatus got=%h want=1888", o_rddata); end
  endtask

  task automatic test_stall();
    drive(12'h305, 1, 12'h305, 1, 2'b01, 0, 64'h1111, 5'd7, 1);
    step();
    i_ready = 0;
    drive(12'h305, 1, 12'h305, 1, 2'b01, 0, 64'h2222, 5'd8, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%0b want=0", i, o_ready); end
      step();
      total++;
      if ({o_valid, o_rdid, o_rddata} !== {1'b1, 5'd7, exp_rddata}) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%0b/%0d/%h", i, o_valid, o_rdid, o_rddata);
      end
    end
    i_ready = 1;
    #1;
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b want=1", o_ready); end
    step();
    set_idle();
    total++;
    if ({o_rdid, o_rddata} !== {5'd8, 64'h1111}) begin
      bad++; $display("FAIL stall_next got=%0d/%h want=8/1111", o_rdid, o_rddata);
    end
  endtask

  task automatic test_mcycle();
    logic [63:0] v1;
    i_ready = 1;
    rd_csr(12'hB00);
    v1 = o_rddata;
    total++;
    if (v1 !== exp_rddata) begin bad++; $display("FAIL mcycle_first got=%h want=%h", v1, exp_rddata); end
    repeat (9) step();
    rd_csr(12'hB00);
    total++;
    if (o_rddata - v1 !== 64'd10) begin bad++; $display("FAIL mcycle_delta got=%0d want=10", o_rddata - v1); end
    drive(12'hB00, 0, 12'hB00, 1, 2'b01, 0, 64'h0, 5'd0, 0);
    step();
    set_idle();
    repeat (5) step();
    rd_csr(12'hB00);
    total++;
    if (o_rddata !== 64'd5) begin bad++; $display("FAIL mcycle_after_write got=%0d want=5", o_rddata); end
  endtask

  task automatic test_illegal();
    logic [63:0] keep;
    keep = mrd(12'h305);
    drive(12'h7C0, 1, 12'h7C0, 1, 2'b01, 0, 64'hDEAD, 5'd9, 1);
    step();
    set_idle();
    total++;
    if ({o_illegal, o_rdwen, o_redirect, o_rddata} !== {3'b100, 64'h0}) begin
      bad++; $display("FAIL illegal_addr got=%b/%h want=100/0", {o_illegal, o_rdwen, o_redirect}, o_rddata);
    end
    rd_csr(12'h305);
    total++;
    if (o_rddata !== keep) begin bad++; $display("FAIL illegal_nochange got=%h want=%h", o_rddata, keep); end
    keep = mrd(12'h341);
    drive_sys(1, 1, 64'hABC0);
    step();
    set_idle();
    total++;
    if ({o_illegal, o_redirect} !== 2'b10) begin
      bad++; $display("FAIL illegal_conflict got=%b want=10", {o_illegal, o_redirect});
    end
    rd_csr(12'h341);
    total++;
    if (o_rddata !== keep) begin bad++; $display("FAIL conflict_mepc got=%h want=%h", o_rddata, keep); end
  endtask

  task automatic test_reset_mid_stall();
    i_ready = 0;
    drive(12'h305, 0, 12'h305, 1, 2'b01, 0, 64'h55, 5'd3, 1);
    step();
    drive(12'h305, 0, 12'h305, 1, 2'b01, 0, 64'h66, 5'd4, 1);
    #2;
    i_rst_n = 0;
    #1;
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%0b want=0", o_valid); end
    mdl_reset();
    set_idle();
    i_ready = 1;
    @(posedge i_clk);
    #1;
    i_rst_n = 1;
    rd_csr(12'h305);
    total++;
    if (o_rddata !== 64'h0) begin bad++; $display("FAIL async_reset_mtvec got=%h want=0", o_rddata); end
  endtask

  task automatic test_random();
    logic [11:0] a, b;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 11);
      a = pick_addr($urandom_range(0, 5));
      b = pick_addr($urandom_range(0, 5));
      if (r == 0) drive_sys(1, 0, {$urandom, $urandom});
      else if (r == 1) drive_sys(0, 1, {$urandom, $urandom});
      else if (r == 2) drive_sys(1, 1, {$urandom, $urandom});
      else if (r == 3) set_idle();
      else drive(a, 1'($urandom), b, 1'($urandom), 2'($urandom_range(1, 3)), 1'($urandom),
                 {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      if (r == 2 || r == 0) i_rdwen = 1'($urandom);
      i_ready = ($urandom_range(0, 9) < 7);
      #1;
      total++;
      if (o_ready !== (!exp_valid || i_ready)) begin
        bad++; $display("FAIL rnd_ready n=%0d got=%0b", n, o_ready);
      end
      step();
      total++;
      if ({o_valid, o_rdid, o_rdwen, o_rddata, o_redirect, o_npc, o_illegal} !==
          {exp_valid, exp_rdid, exp_rdwen, exp_rddata, exp_redirect, exp_npc, exp_illegal}) begin
        bad++;
        $display("FAIL rnd_out n=%0d got=%0b/%0d/%0b/%h/%0b/%h/%0b want=%0b/%0d/%0b/%h/%0b/%h/%0b",
                 n, o_valid, o_rdid, o_rdwen, o_rddata, o_redirect, o_npc, o_illegal, exp_valid,
                 exp_rdid, exp_rdwen, exp_rddata, exp_redirect, exp_npc, exp_illegal);
      end
    end
    set_idle();
    i_ready = 1;
  endtask

  function automatic logic [11:0] pick_addr(input int k);
    case (k)
      0:       return 12'h300;
      1:       return 12'h305;
      2:       return 12'h341;
      3:       return 12'h342;
      4:       return 12'hB00;
      default: return 12'h7C0;
    endcase
  endfunction

  initial begin
    total = 0;
    bad = 0;
    i_rst_n = 0;
    i_ready = 1;
    set_idle();
    mdl_reset();
    test_reset();
    test_rw_mtvec();
    test_mstatus_rc();
    test_ecall_mret();
    test_stall();
    test_mcycle();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
